// File: rtl/pwmtimer_cfg_sequencer_if.sv
// Configuration handshake from the register side plus the timer control bus driven by the sequencer.
interface pwmtimer_cfg_sequencer_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_countmax;
   logic [15:0] cfg_init_carr;
   logic [1:0]  cfg_count_mode;
   logic [2:0]  cfg_syncmode;
   logic        cfg_restart;
   logic        sync;
   logic [15:0] tmr_countmax;
   logic [15:0] tmr_init_carr;
   logic [1:0]  tmr_count_mode;
   logic [2:0]  tmr_syncmode;
   logic        tmr_ce;
   logic        tmr_rst;
   logic        update_done;
   logic        cfg_err;
   logic        busy;

   modport master (
      output cfg_valid, cfg_countmax, cfg_init_carr, cfg_count_mode, cfg_syncmode, cfg_restart, sync,
      input  cfg_ready, tmr_countmax, tmr_init_carr, tmr_count_mode, tmr_syncmode, tmr_ce, tmr_rst,
             update_done, cfg_err, busy
   );

   modport slave (
      input  cfg_valid, cfg_countmax, cfg_init_carr, cfg_count_mode, cfg_syncmode, cfg_restart, sync,
      output cfg_ready, tmr_countmax, tmr_init_carr, tmr_count_mode, tmr_syncmode, tmr_ce, tmr_rst,
             update_done, cfg_err, busy
   );
endinterface

// File: rtl/pwmtimer_cfg_sequencer.sv
// Shadow-register sequencer: applies a config set at the next timer sync, or at once with a timer restart.
// Outputs registered; one set in flight, cfg_ready only in IDLE.
module pwmtimer_cfg_sequencer #(
   parameter int          RST_CYCLES     = 2,
   parameter int          TIMEOUT_CYCLES = 65536,
   parameter logic [15:0] DEF_COUNTMAX   = 16'h00FF
) (
   input logic                    clk,
   input logic                    rst,
   pwmtimer_cfg_sequencer_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_RESTART} state_t;

   state_t      r_state;
   logic [15:0] r_sh_countmax;
   logic [15:0] r_sh_init_carr;
   logic [1:0]  r_sh_count_mode;
   logic [2:0]  r_sh_syncmode;
   logic [TW-1:0] r_to_cnt;
   logic [RW-1:0] r_rst_cnt;

   logic [15:0] r_tmr_countmax;
   logic [15:0] r_tmr_init_carr;
   logic [1:0]  r_tmr_count_mode;
   logic [2:0]  r_tmr_syncmode;
   logic        r_tmr_ce;
   logic        r_tmr_rst;
   logic        r_update_done;
   logic        r_cfg_err;
   logic        r_busy;
   logic        r_cfg_ready;

   logic        w_accept;
   logic        w_immediate;
   logic [15:0] w_init_clamped;

   assign w_accept       = bus.cfg_valid & r_cfg_ready;
   assign w_init_clamped = (bus.cfg_init_carr > bus.cfg_countmax) ? bus.cfg_countmax : bus.cfg_init_carr;
   // A stopped timer or mode 00 never produces sync, so waiting would stall forever.
   assign w_immediate    = bus.cfg_restart | ~r_tmr_ce | (r_tmr_count_mode == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_sh_countmax    <= DEF_COUNTMAX;
         r_sh_init_carr   <= 16'h0000;
         r_sh_count_mode  <= 2'b00;
         r_sh_syncmode    <= 3'd3;
         r_to_cnt         <= '0;
         r_rst_cnt        <= '0;
         r_tmr_countmax   <= DEF_COUNTMAX;
         r_tmr_init_carr  <= 16'h0000;
         r_tmr_count_mode <= 2'b00;
         r_tmr_syncmode   <= 3'd3;
         r_tmr_ce         <= 1'b0;
         r_tmr_rst        <= 1'b1;
         r_update_done    <= 1'b0;
         r_cfg_err        <= 1'b0;
         r_busy           <= 1'b0;
         r_cfg_ready      <= 1'b1;
      end else begin
         r_update_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (bus.cfg_countmax == 16'h0000) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_cfg_err       <= 1'b0;
                     r_sh_countmax   <= bus.cfg_countmax;
                     r_sh_init_carr  <= w_init_clamped;
                     r_sh_count_mode <= bus.cfg_count_mode;
                     r_sh_syncmode   <= bus.cfg_syncmode;
                     r_busy          <= 1'b1;
                     r_cfg_ready     <= 1'b0;
                     if (w_immediate) begin
                        r_tmr_countmax   <= bus.cfg_countmax;
                        r_tmr_init_carr  <= w_init_clamped;
                        r_tmr_count_mode <= bus.cfg_count_mode;
                        r_tmr_syncmode   <= bus.cfg_syncmode;
                        r_tmr_rst        <= 1'b1;
                        r_tmr_ce         <= 1'b1;
                        r_rst_cnt        <= '0;
                        r_state          <= S_RESTART;
                     end else begin
                        r_to_cnt <= '0;
                        r_state  <= S_PENDING;
                     end
                  end
               end
            end
            S_PENDING: begin
               if (bus.sync) begin
                  r_tmr_countmax   <= r_sh_countmax;
                  r_tmr_init_carr  <= r_sh_init_carr;
                  r_tmr_count_mode <= r_sh_count_mode;
                  r_tmr_syncmode   <= r_sh_syncmode;
                  r_update_done    <= 1'b1;
                  r_busy           <= 1'b0;
                  r_cfg_ready      <= 1'b1;
                  r_state          <= S_IDLE;
               end else if (r_to_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                  r_cfg_err        <= 1'b1;
                  r_tmr_countmax   <= r_sh_countmax;
                  r_tmr_init_carr  <= r_sh_init_carr;
                  r_tmr_count_mode <= r_sh_count_mode;
                  r_tmr_syncmode   <= r_sh_syncmode;
                  r_tmr_rst        <= 1'b1;
                  r_tmr_ce         <= 1'b1;
                  r_rst_cnt        <= '0;
                  r_state          <= S_RESTART;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_RESTART: begin
               if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
                  r_tmr_rst     <= 1'b0;
                  r_update_done <= 1'b1;
                  r_busy        <= 1'b0;
                  r_cfg_ready   <= 1'b1;
                  r_state       <= S_IDLE;
               end else begin
                  r_rst_cnt <= r_rst_cnt + 1'b1;
               end
            end
            default: begin
               r_busy      <= 1'b0;
               r_cfg_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cfg_ready      = r_cfg_ready;
   assign bus.tmr_countmax   = r_tmr_countmax;
   assign bus.tmr_init_carr  = r_tmr_init_carr;
   assign bus.tmr_count_mode = r_tmr_count_mode;
   assign bus.tmr_syncmode   = r_tmr_syncmode;
   assign bus.tmr_ce         = r_tmr_ce;
   assign bus.tmr_rst        = r_tmr_rst;
   assign bus.update_done    = r_update_done;
   assign bus.cfg_err        = r_cfg_err;
   assign bus.busy           = r_busy;

endmodule
